elevator_request_scheduler: RTL
===============================

Name: elevator_request_scheduler

Overview:
- Collects floor calls from buttons into a pending-request bitmap.
- Picks the next target floor using a LOOK policy: keep the current direction while calls remain ahead, otherwise reverse.
- Drives the elevator state machine's requested_floor input and reads back current_floor.
- Sequences a door-dwell interval at each served floor. Sits between the button inputs (ui_in) and the elevator car controller in the top level.

Parameters:
- NUM_FLOORS, 10, number of served floors 0..NUM_FLOORS-1; legal range 2..16.
- DOOR_TICKS, 16, number of clk cycles door_open stays high per stop; must be ≥1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- call_valid  input  1  one-cycle strobe: register a call for call_floor
- call_floor  input  4  floor being called
- current_floor  input  4  car position reported by the elevator state machine
- target_floor  output  4  floor the car must travel to; connects to requested_floor
- target_valid  output  1  high when target_floor holds a pending call
- direction  output  2  00 idle, 10 up, 11 down
- door_open  output  1  high during door dwell
- pending  output  NUM_FLOORS  registered call bitmap; bit i = floor i waiting

Behaviour:
- Reset (async, rst_n=0) forces every output and all state to reset values immediately:
  - state=IDLE, pending=0, target_floor=0, target_valid=0, direction=00, door_open=0, dwell counter=0.
- Call capture:
  - On a clk edge with call_valid=1 and call_floor<NUM_FLOORS, set pending[call_floor].
  - Out-of-range floors (≥NUM_FLOORS) are ignored.
  - Duplicate calls are idempotent.
  - A call is visible in pending one cycle after the strobe.
- States are IDLE, UP, DOWN, DOOR. The direction output is 00 in IDLE, 10 in UP and 11 in DOWN, and holds its last value in DOOR.
- IDLE:
  - pending=0 → stay in IDLE, target_valid=0.
  - pending[current_floor]=1 → go to DOOR.
  - Else, any bit above current_floor → UP.
  - Else → DOWN.
  - When IDLE sees both up and down calls, up wins.
- UP:
  - target_floor = lowest pending floor strictly above current_floor, target_valid=1.
  - Re-evaluated every cycle, so a newer closer call pre-empts the old target.
  - On current_floor==target_floor → DOOR.
  - If no bit above current_floor remains, go to DOWN when bits below exist, otherwise IDLE.
- DOWN: mirror of UP, using the highest pending floor strictly below current_floor.
- DOOR:
  - On entry, clear pending[current_floor], set door_open=1, load the dwell counter with DOOR_TICKS-1.
  - door_open stays high for exactly DOOR_TICKS cycles. target_valid=0 and target_floor holds current_floor, so the car stays stopped.
  - A new call for current_floor arriving during DOOR is absorbed: the bit is not set and the dwell does not restart.
  - At counter==0: continue in the previous direction if calls remain ahead, else reverse if calls remain behind, else IDLE.
- Simultaneous events:
  - A call strobe on the same edge as the clear of that floor leaves the bit cleared.
  - A call strobe for any other floor is captured normally.
- Widths:
  - All floor comparisons are unsigned 4-bit.
  - Floors 0 and NUM_FLOORS-1 are boundaries: at floor 0 there is no "below", at NUM_FLOORS-1 there is no "above".
  - Nothing wraps.
- Reset mid-operation (including during DOOR) discards all pending calls and returns to IDLE with door_open=0.
- Selection logic is a priority scan over NUM_FLOORS bits. No latches; outputs are registered.

Test Plan:
- Reset, current_floor=0, call floor 3 → pending=0x008 next cycle; direction=10, target_floor=3, target_valid=1; when current_floor reaches 3, door_open high for 16 cycles, pending=0, then IDLE.
- current_floor=5, calls 2 and 8 on the same cycle → go UP to 8 first, dwell, then DOWN to 2 (direction 11), then IDLE.
- Moving UP from 1 toward 7, call floor 4 injected while current_floor=2 → target_floor switches to 4 next cycle; 7 is served after the stop at 4.
- IDLE at floor 6, call floor 6 → DOOR immediately, direction stays 00, door_open for DOOR_TICKS cycles; repeated 6 calls during dwell do not set pending[6] or extend dwell.
- call_floor=12 with NUM_FLOORS=10 → pending unchanged, state stays IDLE.
- Assert rst_n=0 mid-DOOR with pending=0x0A0 → door_open, pending, target_valid and direction all 0 without waiting for a clk edge; after release, state is IDLE.

Source files
------------

// File: rtl/elevator_request_scheduler.sv
// Elevator request scheduler: latches floor calls into a pending bitmap, chooses the next
// target with a LOOK policy and sequences a fixed door dwell at every served floor.
module elevator_request_scheduler #(
    parameter int NUM_FLOORS = 10,
    parameter int DOOR_TICKS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  call_valid,
    input  logic [3:0]            call_floor,
    input  logic [3:0]            current_floor,
    output logic [3:0]            target_floor,
    output logic                  target_valid,
    output logic [1:0]            direction,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);
    localparam int CW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b10;
    localparam logic [1:0] DIR_DOWN = 2'b11;

    typedef enum logic [1:0] {IDLE, UP, DOWN, DOOR} state_t;
    typedef enum logic [2:0] {ACT_HOLD, ACT_UP, ACT_DOWN, ACT_IDLE, ACT_DOOR} action_t;

    state_t                state_q, state_d;
    action_t               act;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [3:0]            target_q, target_d;
    logic                  target_valid_q, target_valid_d;
    logic [1:0]            direction_q, direction_d;
    logic                  door_open_q, door_open_d;
    logic [CW-1:0]         dwell_q, dwell_d;

    logic       has_up, has_down, here;
    logic [3:0] up_floor, down_floor;

    // Priority scans: nearest call strictly above / strictly below the car.
    always_comb begin
        has_up     = 1'b0;
        has_down   = 1'b0;
        here       = 1'b0;
        up_floor   = '0;
        down_floor = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (4'(i) > current_floor)) begin
                has_up   = 1'b1;
                up_floor = 4'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (4'(i) < current_floor)) begin
                has_down   = 1'b1;
                down_floor = 4'(i);
            end
            if (4'(i) == current_floor) begin
                here = pending_q[i];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        target_d       = target_q;
        target_valid_d = target_valid_q;
        direction_d    = direction_q;
        door_open_d    = door_open_q;
        dwell_d        = dwell_q;
        act            = ACT_HOLD;

        // A call for the floor the doors are already open at is absorbed.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (call_valid && (4'(i) == call_floor) &&
                !((state_q == DOOR) && (call_floor == current_floor))) begin
                pending_d[i] = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (here)          act = ACT_DOOR;
                else if (has_up)   act = ACT_UP;
                else if (has_down) act = ACT_DOWN;
                else               act = ACT_IDLE;
            end
            UP: begin
                if (current_floor == target_q) act = ACT_DOOR;
                else if (has_up)               act = ACT_UP;
                else if (has_down)             act = ACT_DOWN;
                else                           act = ACT_IDLE;
            end
            DOWN: begin
                if (current_floor == target_q) act = ACT_DOOR;
                else if (has_down)             act = ACT_DOWN;
                else if (has_up)               act = ACT_UP;
                else                           act = ACT_IDLE;
            end
            DOOR: begin
                if (dwell_q != '0) begin
                    dwell_d = dwell_q - 1'b1;
                end else if (direction_q == DIR_DOWN) begin
                    if (has_down)    act = ACT_DOWN;
                    else if (has_up) act = ACT_UP;
                    else             act = ACT_IDLE;
                end else begin
                    if (has_up)        act = ACT_UP;
                    else if (has_down) act = ACT_DOWN;
                    else               act = ACT_IDLE;
                end
            end
            default: act = ACT_IDLE;
        endcase

        // The door clear is applied after capture so a same-edge call for this floor loses.
        case (act)
            ACT_UP: begin
                state_d        = UP;
                target_d       = up_floor;
                target_valid_d = 1'b1;
                direction_d    = DIR_UP;
                door_open_d    = 1'b0;
            end
            ACT_DOWN: begin
                state_d        = DOWN;
                target_d       = down_floor;
                target_valid_d = 1'b1;
                direction_d    = DIR_DOWN;
                door_open_d    = 1'b0;
            end
            ACT_IDLE: begin
                state_d        = IDLE;
                target_valid_d = 1'b0;
                direction_d    = DIR_IDLE;
                door_open_d    = 1'b0;
            end
            ACT_DOOR: begin
                state_d        = DOOR;
                target_d       = current_floor;
                target_valid_d = 1'b0;
                door_open_d    = 1'b1;
                dwell_d        = CW'(DOOR_TICKS - 1);
                for (int i = 0; i < NUM_FLOORS; i++) begin
                    if (4'(i) == current_floor) begin
                        pending_d[i] = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pending_q      <= '0;
            target_q       <= '0;
            target_valid_q <= 1'b0;
            direction_q    <= DIR_IDLE;
            door_open_q    <= 1'b0;
            dwell_q        <= '0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            target_q       <= target_d;
            target_valid_q <= target_valid_d;
            direction_q    <= direction_d;
            door_open_q    <= door_open_d;
            dwell_q        <= dwell_d;
        end
    end

    assign target_floor = target_q;
    assign target_valid = target_valid_q;
    assign direction    = direction_q;
    assign door_open    = door_open_q;
    assign pending      = pending_q;

endmodule
